// File: rtl/bird_pipe_referee.sv
// rtl/bird_pipe_referee.sv - pipe scroller, collision referee and IDLE/PLAY/DEAD game FSM
//
// Purpose: owns one scrolling pipe pair, randomises its gap with an 8-bit
// LFSR, detects bird/pipe/ground/ceiling collisions, counts passed pipes and
// freezes the bird outside of play. All state advances once per frame.
//
// Ports:
//   frame_clk   in   frame tick, all state updates on posedge
//   Reset       in   asynchronous, active-high
//   keycode     in   [7:0] current keycode, 8'h00 = none
//   BallX/Y     in   [9:0] bird centre
//   BallS       in   [9:0] bird half-size (box = centre +/- BallS)
//   PipeX       out  [9:0] pipe left edge
//   GapY        out  [9:0] top of gap
//   Score       out  [7:0] pipes passed, saturating
//   GameState   out  [1:0] 00 IDLE, 01 PLAY, 10 DEAD
//   Hit         out  one-frame pulse in the first DEAD frame
//   FreezeBall  out  high whenever not in PLAY
//   HiScore     out  [7:0] best score, only when HIGH_SCORE_EN is defined
//
// Configuration macro: HIGH_SCORE_EN

module bird_pipe_referee #(
  parameter int          SCREEN_W    = 640,
  parameter int          GROUND_Y    = 479,
  parameter int          PIPE_W      = 60,
  parameter int          GAP_H       = 120,
  parameter int          GAP_BASE    = 40,
  parameter int          SCROLL_STEP = 2,
  parameter int          DEAD_HOLD   = 120,
  parameter logic [7:0]  FLAP_KEY    = 8'h1A
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  output logic [9:0] PipeX,
  output logic [9:0] GapY,
  output logic [7:0] Score,
  output logic [1:0] GameState,
  output logic       Hit,
  output logic       FreezeBall
`ifdef HIGH_SCORE_EN
  ,
  output logic [7:0] HiScore
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DEAD = 2'b10
  } state_t;

  localparam logic [9:0]  RESPAWN_X = 10'(SCREEN_W - 1);
  localparam logic [9:0]  STEP      = 10'(SCROLL_STEP);
  localparam logic [7:0]  HOLD      = 8'(DEAD_HOLD);

  state_t     state, state_n;
  logic [9:0] pipe_x_n, gap_y_n;
  logic [7:0] score_n;
  logic       scored, scored_n;
  logic       hit_n;
  logic [7:0] dead_cnt, dead_cnt_n;
  logic [7:0] lfsr, lfsr_n;
  logic [9:0] gap_reload;
`ifdef HIGH_SCORE_EN
  logic [7:0] hi_n;
`endif

  // One extra bit so sums of two 10-bit values never wrap; no subtraction
  // anywhere, so nothing can go negative near the screen edges.
  logic [10:0] bx, by, bs, px, gy;
  logic        xov, outg, crash, passed;

  assign bx = {1'b0, BallX};
  assign by = {1'b0, BallY};
  assign bs = {1'b0, BallS};
  assign px = {1'b0, PipeX};
  assign gy = {1'b0, GapY};

  assign xov    = (bx + bs >= px) && (bx <= px + 11'(PIPE_W - 1) + bs);
  assign outg   = (by < gy + bs) || (by + bs > gy + 11'(GAP_H));
  assign crash  = (xov && outg) || (by + bs >= 11'(GROUND_Y)) || (by <= bs);
  // Pipe right edge has cleared the bird's left edge.
  assign passed = !scored && (px + 11'(PIPE_W) + bs < bx);

  // Fibonacci taps 8,6,5,4; the all-zero state is unreachable from 8'hA5.
  assign lfsr_n     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign gap_reload = 10'(GAP_BASE) + {2'b00, lfsr};

  assign GameState  = state;
  assign FreezeBall = (state != PLAY);

  always_comb begin
    state_n    = state;
    pipe_x_n   = PipeX;
    gap_y_n    = GapY;
    score_n    = Score;
    scored_n   = scored;
    hit_n      = 1'b0;
    dead_cnt_n = dead_cnt;
`ifdef HIGH_SCORE_EN
    hi_n       = HiScore;
`endif
    case (state)
      PLAY: begin
        if (crash) begin
          state_n    = DEAD;
          hit_n      = 1'b1;
          dead_cnt_n = 8'd0;
`ifdef HIGH_SCORE_EN
          if (Score > HiScore) hi_n = Score;
`endif
        end else if (PipeX <= STEP) begin
          pipe_x_n = RESPAWN_X;
          gap_y_n  = gap_reload;
          scored_n = 1'b0;
        end else begin
          pipe_x_n = PipeX - STEP;
          if (passed) begin
            score_n  = (Score == 8'hFF) ? Score : Score + 8'd1;
            scored_n = 1'b1;
          end
        end
      end
      DEAD: begin
        // Leaving requires the key to be up, so a flap held through the
        // crash cannot immediately restart the game.
        if (dead_cnt == HOLD && keycode != FLAP_KEY) state_n = IDLE;
        else if (dead_cnt < HOLD) dead_cnt_n = dead_cnt + 8'd1;
      end
      default: begin
        // IDLE, and the unused encoding 2'b11 which behaves as IDLE.
        if (keycode == FLAP_KEY) begin
          state_n  = PLAY;
          score_n  = 8'd0;
          pipe_x_n = RESPAWN_X;
          gap_y_n  = gap_reload;
          scored_n = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      PipeX    <= RESPAWN_X;
      GapY     <= 10'(GAP_BASE) + 10'h0A5;
      Score    <= 8'd0;
      scored   <= 1'b0;
      Hit      <= 1'b0;
      dead_cnt <= 8'd0;
      lfsr     <= 8'hA5;
`ifdef HIGH_SCORE_EN
      HiScore  <= 8'd0;
`endif
    end else begin
      state    <= state_n;
      PipeX    <= pipe_x_n;
      GapY     <= gap_y_n;
      Score    <= score_n;
      scored   <= scored_n;
      Hit      <= hit_n;
      dead_cnt <= dead_cnt_n;
      lfsr     <= lfsr_n;
`ifdef HIGH_SCORE_EN
      HiScore  <= hi_n;
`endif
    end
  end

endmodule

// File: tb/tb_bird_pipe_referee.sv
// tb/tb_bird_pipe_referee.sv - scoreboard bench for bird_pipe_referee

module tb_bird_pipe_referee;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic [9:0] BallX, BallY, BallS;
  logic [9:0] PipeX, GapY;
  logic [7:0] Score;
  logic [1:0] GameState;
  logic       Hit, FreezeBall;
`ifdef HIGH_SCORE_EN
  logic [7:0] HiScore;
`endif

  bird_pipe_referee dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .BallX      (BallX),
    .BallY      (BallY),
    .BallS      (BallS),
    .PipeX      (PipeX),
    .GapY       (GapY),
    .Score      (Score),
    .GameState  (GameState),
    .Hit        (Hit),
    .FreezeBall (FreezeBall)
`ifdef HIGH_SCORE_EN
    ,
    .HiScore    (HiScore)
`endif
  );

  always #5 frame_clk = ~frame_clk;

  // Mask bits: 0 PipeX, 1 GapY, 2 Score, 3 GameState, 4 Hit, 5 FreezeBall, 6 HiScore
  typedef struct {
    string      name;
    int         at;
    int         pipex, gapy, score, st, hit, frz, hi;
    logic [6:0] mask;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference state
  int         m_state, m_pipex, m_gapy, m_score, m_scored, m_hit, m_cnt, m_hi;
  logic [7:0] m_lfsr;

  always @(posedge frame_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s.%s at frame %0d: got %0d expected %0d", nm, fld, cyc, act, expv);
    end
  endtask

  // Monitor: compares every queued expectation on the frame it targets.
  always @(negedge frame_clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      if (cur.at != cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for frame %0d reached monitor at frame %0d", cur.name, cur.at, cyc);
      end else begin
        if (cur.mask[0]) chk(cur.name, "PipeX", int'(PipeX), cur.pipex);
        if (cur.mask[1]) chk(cur.name, "GapY", int'(GapY), cur.gapy);
        if (cur.mask[2]) chk(cur.name, "Score", int'(Score), cur.score);
        if (cur.mask[3]) chk(cur.name, "GameState", int'(GameState), cur.st);
        if (cur.mask[4]) chk(cur.name, "Hit", int'(Hit), cur.hit);
        if (cur.mask[5]) chk(cur.name, "FreezeBall", int'(FreezeBall), cur.frz);
`ifdef HIGH_SCORE_EN
        if (cur.mask[6]) chk(cur.name, "HiScore", int'(HiScore), cur.hi);
`endif
      end
    end
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic model_reset();
    m_state = 0; m_pipex = 639; m_gapy = 205; m_score = 0; m_scored = 0;
    m_hit = 0; m_cnt = 0; m_hi = 0; m_lfsr = 8'hA5;
  endtask

  task automatic tick();
    @(negedge frame_clk);
    #1;
  endtask

  task automatic push(input string nm, input int px, input int gy, input int sc,
                      input int st, input int ht, input int fz, input int hi,
                      input logic [6:0] mask);
    exp_t e;
    e.name = nm; e.at = cyc + 1; e.pipex = px; e.gapy = gy; e.score = sc;
    e.st = st; e.hit = ht; e.frz = fz; e.hi = hi; e.mask = mask;
    sb.push_back(e);
  endtask

  // Drive one frame of inputs, advance the reference, queue its prediction.
  task automatic apply(input logic [7:0] k, input int bx, input int by, input int bs);
    int left, right, top, bot;
    bit crash;
    keycode = k; BallX = 10'(bx); BallY = 10'(by); BallS = 10'(bs);
    left = bx - bs; right = bx + bs; top = by - bs; bot = by + bs;
    case (m_state)
      0: begin
        m_hit = 0;
        if (k == 8'h1A) begin
          m_state = 1; m_score = 0; m_pipex = 639; m_gapy = 40 + int'(m_lfsr); m_scored = 0;
        end
      end
      1: begin
        crash = (right >= m_pipex && left <= m_pipex + 59 && (top < m_gapy || bot > m_gapy + 120))
                || bot >= 479 || top <= 0;
        if (crash) begin
          m_state = 2; m_hit = 1; m_cnt = 0;
          if (m_score > m_hi) m_hi = m_score;
        end else begin
          m_hit = 0;
          if (m_pipex <= 2) begin
            m_pipex = 639; m_gapy = 40 + int'(m_lfsr); m_scored = 0;
          end else begin
            if (m_scored == 0 && m_pipex + 60 < left) begin
              m_score = (m_score == 255) ? 255 : m_score + 1;
              m_scored = 1;
            end
            m_pipex = m_pipex - 2;
          end
        end
      end
      default: begin
        m_hit = 0;
        if (m_cnt == 120 && k != 8'h1A) m_state = 0;
        else if (m_cnt < 120) m_cnt++;
      end
    endcase
    m_lfsr = lfsr_step(m_lfsr);
    push("frame", m_pipex, m_gapy, m_score, m_state, m_hit, (m_state != 1) ? 1 : 0, m_hi, 7'h7F);
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: frame budget expired", nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p, n;
    bit first31, first29, first1;
    Reset = 1'b1; keycode = 8'h00; BallX = 10'd100; BallY = 10'd265; BallS = 10'd10;
    model_reset();
    tick();
    push("reset", 639, 205, 0, 0, 0, 1, 0, 7'h7F);
    tick();
    Reset = 1'b0;

    // IDLE holds the pipe
    for (int i = 0; i < 3; i++) begin
      apply(8'h00, 100, m_gapy + 60, 10);
      if (i == 2) push("idle_hold", 639, 205, 0, 0, 0, 1, 0, 7'h3B);
      tick();
    end

    // Start
    apply(8'h1A, 100, m_gapy + 60, 10);
    push("start", 0, 0, 0, 1, 0, 0, 0, 7'h28);
    tick();
    for (int i = 0; i < 10; i++) begin
      apply(8'h00, 100, m_gapy + 60, 10);
      if (i == 9) push("scroll10", 619, 0, 0, 0, 0, 0, 0, 7'h01);
      tick();
    end

    // Fly through the gap until two pipes are passed
    first31 = 1; first29 = 1; first1 = 1; n = 0;
    while (m_score < 2 && n < 1500) begin
      p = m_pipex;
      apply(8'h00, 100, m_gapy + 60, 10);
      if (p == 31 && first31) begin push("pre_score", 29, 0, 0, 0, 0, 0, 0, 7'h05); first31 = 0; end
      if (p == 29 && first29) begin push("score1", 27, 0, 1, 0, 0, 0, 0, 7'h05); first29 = 0; end
      if (p == 1 && first1) begin push("wrap", 639, 0, 1, 1, 0, 0, 0, 7'h0D); first1 = 0; end
      tick();
      n++;
    end
    if (m_score < 2) timeout("play_two_pipes");

    // Ground crash
    p = m_pipex;
    apply(8'h00, 100, 430, 50);
    push("ground_crash", p, 0, 2, 2, 1, 1, 0, 7'h3D);
    tick();
    apply(8'h1A, 100, 430, 50);
    push("hit_pulse_end", p, 0, 2, 2, 0, 1, 0, 7'h3D);
    tick();
    for (int i = 0; i < 130; i++) begin
      apply(8'h1A, 100, 430, 50);
      if (i == 129) push("dead_key_held", 0, 0, 0, 2, 0, 1, 0, 7'h28);
      tick();
    end
    apply(8'h00, 100, 430, 50);
    push("dead_release", 0, 0, 0, 0, 0, 1, 0, 7'h28);
    tick();

    // Second run: side crash in the same frame the pipe would wrap
    apply(8'h1A, 100, 265, 10);
    tick();
    n = 0;
    while (m_pipex > 2 && n < 400) begin
      apply(8'h00, 100, m_gapy + 60, 10);
      tick();
      n++;
    end
    if (m_pipex > 2) timeout("reach_edge");
    p = m_pipex;
    apply(8'h00, p + 5, m_gapy - 20, 10);
    push("edge_crash_no_wrap", p, 0, 1, 2, 1, 1, 2, 7'h7D);
    tick();
    n = 0;
    while (m_state == 2 && n < 200) begin
      apply(8'h00, 100, 265, 10);
      tick();
      n++;
    end
    if (m_state == 2) timeout("leave_dead");

    // Asynchronous reset in the middle of play
    apply(8'h1A, 100, m_gapy + 60, 10);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply(8'h00, 100, m_gapy + 60, 10);
      tick();
    end
    Reset = 1'b1;
    model_reset();
    push("midplay_reset", 639, 205, 0, 0, 0, 1, 0, 7'h7F);
    tick();
    Reset = 1'b0;
    apply(8'h00, 100, 265, 10);
    tick();
    tick();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never reached the monitor", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
